slc3_sram_ctrl: RTL and testbench



---
 rtl/slc3_mem_pkg.sv | 24 ++
 rtl/slc3_sram_array.sv | 40 ++++
 rtl/slc3_sram_ctrl.sv | 144 ++++++++++++++
 tb/tb_slc3_sram_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// Purpose: shared types and constants for the SLC-3 on-chip SRAM controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package slc3_mem_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int WORD_W         = 16;

  // Controller FSM: zero-fill after reset, CPU service, loader burst.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // One request on the single memory write port. The address is carried at
  // full CPU width; the array only looks at the low ADDR_W bits.
  typedef struct packed {
    logic              en;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] dat;
  } wr_req_t;

endpackage

// File: rtl/slc3_sram_array.sv
// Purpose: synchronous word RAM, one write port and one registered read port.
// Latency: write commits at the clock edge; read data registered one cycle after rd_en.
// Backpressure: none; rd_dat holds its value while rd_en is low.
module slc3_sram_array
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset so it maps onto block RAM; the controller zero-fills it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Registered read port; only the output register is reset so the CPU sees 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/slc3_sram_ctrl.sv
// Purpose: SLC-3 SRAM controller: post-reset zero-fill, CPU read/write, valid/ready program loader.
// Latency: CPU read data one cycle after OE is sampled low; writes commit at the sampling edge.
// Backpressure: Ld_Ready low only during the zero-fill; CPU strobes are ignored while Busy is high.
module slc3_sram_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = WORD_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic              OE,
  input  logic              WE,
  input  logic [DATA_W-1:0] Data_to_SRAM,
  output logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Busy,
  input  logic              Ld_Valid,
  output logic              Ld_Ready,
  input  logic [15:0]       Ld_Addr,
  input  logic [DATA_W-1:0] Ld_Data,
  input  logic              Ld_Last,
  output logic [ADDR_W:0]   Ld_Count
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] CLR_LAST  = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W:0]   ld_count;
  logic              ld_acc;
  logic              cpu_wr;
  logic              cpu_rd;
  wr_req_t           wr_req;
  logic              unused_addr_bits;

  assign ld_acc   = Ld_Valid && Ld_Ready;
  // The loader wins the write port, so a simultaneous CPU write is dropped.
  assign cpu_wr   = (state == IDLE) && !WE && !ld_acc;
  // A write strobe suppresses the read, leaving Data_from_SRAM unchanged.
  assign cpu_rd   = (state == IDLE) && !OE && WE;
  assign Ld_Count = ld_count;

  // Upper address bits alias onto the implemented words and are ignored.
  assign unused_addr_bits = ^{ADDR[15:ADDR_W], Ld_Addr[15:ADDR_W], wr_req.addr[WORD_W-1:ADDR_W]};

  // State register; reset restarts the zero-fill from any state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    Busy      = 1'b1;
    Ld_Ready  = 1'b0;
    case (state)
      CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        Busy     = 1'b0;
        Ld_Ready = 1'b1;
        // A single-word load (Last on the first word) never leaves IDLE.
        if (Ld_Valid && !Ld_Last) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        Ld_Ready = 1'b1;
        if (Ld_Valid && Ld_Last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Zero-fill address; wraps back to 0 after the last word so a later reset starts clean.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Loader word count: restarts at 1 on the first word of a load, saturates at DEPTH.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ld_count <= '0;
    end else if (ld_acc) begin
      if (state == IDLE) begin
        ld_count <= COUNT_ONE;
      end else if (ld_count != COUNT_MAX) begin
        ld_count <= ld_count + 1'b1;
      end
    end
  end

  // Write-port arbitration: zero-fill, then loader, then CPU.
  always_comb begin
    wr_req = '0;
    if (state == CLEAR) begin
      wr_req.en   = 1'b1;
      wr_req.addr = WORD_W'(clr_cnt);
    end else if (ld_acc) begin
      wr_req.en   = 1'b1;
      wr_req.addr = Ld_Addr;
      wr_req.dat  = WORD_W'(Ld_Data);
    end else if (cpu_wr) begin
      wr_req.en   = 1'b1;
      wr_req.addr = ADDR;
      wr_req.dat  = WORD_W'(Data_to_SRAM);
    end
  end

  slc3_sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (Clk),
    .rst_n   (Reset),
    .wr_en   (wr_req.en),
    .wr_addr (wr_req.addr[ADDR_W-1:0]),
    .wr_dat  (wr_req.dat[DATA_W-1:0]),
    .rd_en   (cpu_rd),
    .rd_addr (ADDR[ADDR_W-1:0]),
    .rd_dat  (Data_from_SRAM)
  );

endmodule

// File: tb/tb_slc3_sram_ctrl.sv
// Purpose: self-checking bench for slc3_sram_ctrl against a word-array reference model.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: every wait on Busy is bounded; an expired bound is reported as a failure.
module tb_slc3_sram_ctrl;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [15:0]   ADDR;
  logic          OE;
  logic          WE;
  logic [15:0]   Data_to_SRAM;
  logic [15:0]   Data_from_SRAM;
  logic          Busy;
  logic          Ld_Valid;
  logic          Ld_Ready;
  logic [15:0]   Ld_Addr;
  logic [15:0]   Ld_Data;
  logic          Ld_Last;
  logic [ADDR_W:0] Ld_Count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: plain word array plus load bookkeeping.
  logic [15:0] model_mem [DEPTH];
  int          model_cnt;
  bit          model_loading;

  always #5 Clk = ~Clk;

  slc3_sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ADDR           (ADDR),
    .OE             (OE),
    .WE             (WE),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_from_SRAM (Data_from_SRAM),
    .Busy           (Busy),
    .Ld_Valid       (Ld_Valid),
    .Ld_Ready       (Ld_Ready),
    .Ld_Addr        (Ld_Addr),
    .Ld_Data        (Ld_Data),
    .Ld_Last        (Ld_Last),
    .Ld_Count       (Ld_Count)
  );

  function automatic int widx(input logic [15:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    model_cnt     = 0;
    model_loading = 0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input bit applies);
    @(negedge Clk);
    ADDR = a; Data_to_SRAM = d; WE = 1'b0; OE = 1'b1;
    @(posedge Clk); #1;
    WE = 1'b1;
    if (applies) model_mem[widx(a)] = d;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge Clk);
    ADDR = a; OE = 1'b0; WE = 1'b1;
    @(posedge Clk); #1;
    d  = Data_from_SRAM;
    OE = 1'b1;
  endtask

  task automatic ld_send(input logic [15:0] a, input logic [15:0] d, input bit last);
    @(negedge Clk);
    Ld_Valid = 1'b1; Ld_Addr = a; Ld_Data = d; Ld_Last = last;
    @(posedge Clk); #1;
    Ld_Valid = 1'b0; Ld_Last = 1'b0;
    model_mem[widx(a)] = d;
    if (!model_loading) model_cnt = 1;
    else if (model_cnt < DEPTH) model_cnt++;
    model_loading = !last;
  endtask

  // Releases reset and measures how many edges Busy stays high.
  task automatic release_and_clear(input string tag);
    int n;
    @(negedge Clk);
    Reset = 1'b1;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (Busy === 1'b1 && n < 2000);
    model_reset();
    tests_run++;
    if (n != DEPTH) begin
      tests_failed++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", tag, n, DEPTH);
    end
    tests_run++;
    if (Ld_Ready !== 1'b1 || Ld_Count !== 11'd0) begin
      tests_failed++;
      $display("FAIL %s_after_clear: Ld_Ready=%b Ld_Count=%0d want 1/0", tag, Ld_Ready, Ld_Count);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; OE = 1'b1; WE = 1'b1; ADDR = '0; Data_to_SRAM = '0;
    Ld_Valid = 1'b0; Ld_Addr = '0; Ld_Data = '0; Ld_Last = 1'b0;
    #1 Reset = 1'b0;
    #3;
    tests_run++;
    if (Busy !== 1'b1 || Ld_Ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: Busy=%b Ld_Ready=%b want 1/0", Busy, Ld_Ready);
    end
    tests_run++;
    if (Ld_Count !== 11'd0 || Data_from_SRAM !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_regs: Ld_Count=%0d Data=%h want 0/0000", Ld_Count, Data_from_SRAM);
    end
    repeat (3) @(negedge Clk);
    release_and_clear("reset");
  endtask

  task automatic test_clear_reads();
    logic [15:0] addrs [3];
    logic [15:0] d;
    addrs[0] = 16'h0000; addrs[1] = 16'h0155; addrs[2] = 16'h03FF;
    for (int i = 0; i < 3; i++) begin
      cpu_read(addrs[i], d);
      tests_run++;
      if (d !== 16'h0000) begin
        tests_failed++;
        $display("FAIL clear_read[%h]: got %h want 0000", addrs[i], d);
      end
    end
  endtask

  task automatic test_cpu_write_read();
    logic [15:0] d;
    cpu_write(16'h0012, 16'hBEEF, 1);
    cpu_read(16'h0012, d);
    tests_run++;
    if (d !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL raw_read: got %h want BEEF", d);
    end
    repeat (2) @(negedge Clk);
    tests_run++;
    if (Data_from_SRAM !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL oe_high_hold: got %h want BEEF", Data_from_SRAM);
    end
    // Both strobes low: write lands, read output must hold.
    @(negedge Clk);
    ADDR = 16'h0020; Data_to_SRAM = 16'h5A5A; WE = 1'b0; OE = 1'b0;
    @(posedge Clk); #1;
    WE = 1'b1; OE = 1'b1;
    model_mem[widx(16'h0020)] = 16'h5A5A;
    tests_run++;
    if (Data_from_SRAM !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL both_strobes_hold: got %h want BEEF", Data_from_SRAM);
    end
    cpu_read(16'h0020, d);
    tests_run++;
    if (d !== 16'h5A5A) begin
      tests_failed++;
      $display("FAIL both_strobes_write: got %h want 5A5A", d);
    end
  endtask

  task automatic test_alias();
    logic [15:0] d;
    cpu_write(16'h0412, 16'h1234, 1);
    cpu_read(16'h0012, d);
    tests_run++;
    if (d !== 16'h1234) begin
      tests_failed++;
      $display("FAIL alias_read: got %h want 1234", d);
    end
  endtask

  task automatic test_load();
    logic [15:0] exp [3];
    logic [15:0] d;
    exp[0] = 16'h5020; exp[1] = 16'h1221; exp[2] = 16'h0FFE;
    ld_send(16'h0000, exp[0], 0);
    tests_run++;
    if (Busy !== 1'b1 || Ld_Count !== 11'd1) begin
      tests_failed++;
      $display("FAIL load_first: Busy=%b Ld_Count=%0d want 1/1", Busy, Ld_Count);
    end
    repeat (2) @(negedge Clk);
    tests_run++;
    if (Busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_gap_busy: got %b want 1", Busy);
    end
    ld_send(16'h0001, exp[1], 0);
    repeat (1) @(negedge Clk);
    ld_send(16'h0002, exp[2], 1);
    tests_run++;
    if (Busy !== 1'b0 || Ld_Count !== 11'd3) begin
      tests_failed++;
      $display("FAIL load_end: Busy=%b Ld_Count=%0d want 0/3", Busy, Ld_Count);
    end
    for (int i = 0; i < 3; i++) begin
      cpu_read(16'(i), d);
      tests_run++;
      if (d !== exp[i]) begin
        tests_failed++;
        $display("FAIL load_readback[%0d]: got %h want %h", i, d, exp[i]);
      end
    end
    tests_run++;
    if (Ld_Count !== 11'd3) begin
      tests_failed++;
      $display("FAIL load_count_hold: got %0d want 3", Ld_Count);
    end
  endtask

  task automatic test_load_cpu_ignored();
    logic [15:0] d;
    cpu_read(16'h0002, d);
    ld_send(16'h0060, 16'hC0DE, 0);
    cpu_write(16'h0050, 16'hAAAA, 0);
    cpu_read(16'h0060, d);
    tests_run++;
    if (d !== 16'h0FFE) begin
      tests_failed++;
      $display("FAIL load_read_held: got %h want 0FFE", d);
    end
    ld_send(16'h0061, 16'hD00D, 1);
    cpu_read(16'h0050, d);
    tests_run++;
    if (d !== 16'h0000) begin
      tests_failed++;
      $display("FAIL load_cpu_write_ignored: got %h want 0000", d);
    end
    cpu_read(16'h0060, d);
    tests_run++;
    if (d !== 16'hC0DE) begin
      tests_failed++;
      $display("FAIL load_word_0060: got %h want C0DE", d);
    end
  endtask

  task automatic test_loader_wins();
    logic [15:0] d;
    @(negedge Clk);
    ADDR = 16'h0070; Data_to_SRAM = 16'h7777; WE = 1'b0;
    Ld_Valid = 1'b1; Ld_Addr = 16'h0071; Ld_Data = 16'h7171; Ld_Last = 1'b1;
    @(posedge Clk); #1;
    WE = 1'b1; Ld_Valid = 1'b0; Ld_Last = 1'b0;
    model_mem[widx(16'h0071)] = 16'h7171;
    model_cnt = 1; model_loading = 0;
    tests_run++;
    if (Busy !== 1'b0 || Ld_Count !== 11'd1) begin
      tests_failed++;
      $display("FAIL single_word_load: Busy=%b Ld_Count=%0d want 0/1", Busy, Ld_Count);
    end
    cpu_read(16'h0070, d);
    tests_run++;
    if (d !== model_mem[widx(16'h0070)]) begin
      tests_failed++;
      $display("FAIL cpu_write_dropped: got %h want %h", d, model_mem[widx(16'h0070)]);
    end
    cpu_read(16'h0071, d);
    tests_run++;
    if (d !== 16'h7171) begin
      tests_failed++;
      $display("FAIL loader_write_won: got %h want 7171", d);
    end
  endtask

  task automatic test_ld_count_sat();
    logic [15:0] d;
    logic [15:0] a;
    for (int i = 0; i < DEPTH + 6; i++) begin
      ld_send(16'(i), 16'($urandom), i == DEPTH + 5);
      if (i == DEPTH - 2 || i == DEPTH - 1 || i == DEPTH + 5) begin
        tests_run++;
        if (int'(Ld_Count) != model_cnt) begin
          tests_failed++;
          $display("FAIL ld_count_sat[%0d]: got %0d want %0d", i, Ld_Count, model_cnt);
        end
      end
    end
    for (int k = 0; k < 12; k++) begin
      a = 16'($urandom);
      cpu_read(a, d);
      tests_run++;
      if (d !== model_mem[widx(a)]) begin
        tests_failed++;
        $display("FAIL sat_readback[%h]: got %h want %h", a, d, model_mem[widx(a)]);
      end
    end
  endtask

  task automatic test_random_cpu();
    logic [15:0] model_out;
    logic [15:0] a;
    logic [15:0] d;
    int op;
    cpu_read(16'h0005, d);
    model_out = model_mem[5];
    tests_run++;
    if (d !== model_out) begin
      tests_failed++;
      $display("FAIL rand_seed_read: got %h want %h", d, model_out);
    end
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 3);
      // Small word range plus random upper bits exercises aliasing and read-after-write.
      a  = 16'($urandom_range(0, 15)) | 16'($urandom_range(0, 63) << ADDR_W);
      d  = 16'($urandom);
      @(negedge Clk);
      ADDR = a; Data_to_SRAM = d;
      WE = !(op == 0 || op == 2);
      OE = !(op == 1 || op == 2);
      @(posedge Clk); #1;
      if (!WE) model_mem[widx(a)] = d;
      else if (!OE) model_out = model_mem[widx(a)];
      WE = 1'b1; OE = 1'b1;
      tests_run++;
      if (Data_from_SRAM !== model_out) begin
        tests_failed++;
        $display("FAIL rand_cpu[%0d] op=%0d addr=%h: got %h want %h", i, op, a, Data_from_SRAM, model_out);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] d;
    cpu_write(16'h0003, 16'h3333, 1);
    cpu_read(16'h0003, d);
    tests_run++;
    if (d !== 16'h3333) begin
      tests_failed++;
      $display("FAIL pre_reset_read: got %h want 3333", d);
    end
    ld_send(16'h0100, 16'h1111, 0);
    ld_send(16'h0101, 16'h2222, 0);
    tests_run++;
    if (Ld_Count !== 11'd2 || Busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_load_state: Ld_Count=%0d Busy=%b want 2/1", Ld_Count, Busy);
    end
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    tests_run++;
    if (Busy !== 1'b1 || Ld_Ready !== 1'b0 || Ld_Count !== 11'd0 || Data_from_SRAM !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_reset_mid_load: Busy=%b Ld_Ready=%b Ld_Count=%0d Data=%h want 1/0/0/0000",
               Busy, Ld_Ready, Ld_Count, Data_from_SRAM);
    end
    release_and_clear("mid_load");
    cpu_read(16'h0100, d);
    tests_run++;
    if (d !== 16'h0000) begin
      tests_failed++;
      $display("FAIL mid_load_discard_0100: got %h want 0000", d);
    end
    cpu_read(16'h0101, d);
    tests_run++;
    if (d !== 16'h0000) begin
      tests_failed++;
      $display("FAIL mid_load_discard_0101: got %h want 0000", d);
    end
    cpu_read(16'h0012, d);
    tests_run++;
    if (d !== 16'h0000) begin
      tests_failed++;
      $display("FAIL mid_load_clear_0012: got %h want 0000", d);
    end
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_cpu_write_read();
    test_alias();
    test_load();
    test_load_cpu_ignored();
    test_loader_wins();
    test_ld_count_sat();
    test_random_cpu();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
